vga_scan_driver: RTL and testbench
==================================

# vga_scan_driver

Raster timing generator and VGA pin driver for the 640x480@60 Hz display path. Derives a 25 MHz pixel tick from the 50 MHz system clock and walks horizontal/vertical counters that drive DrawX/DrawY to the colour mapper. Samples the mapper's Red/Green/Blue on each pixel tick, forces black during blanking, and drives the DAC colour, sync and blank pins with sync aligned to colour. Also emits a one-cycle frame-start pulse for game-state logic.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- Clk  in  1  50 MHz system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- pixel_ce  out  1  pixel tick, high every second Clk cycle
- DrawX  out  10  current horizontal count (0..H_TOTAL-1)
- DrawY  out  10  current vertical count (0..V_TOTAL-1)
- Red, Green, Blue  in  8 each  colour for (DrawX, DrawY) from the colour mapper
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour
- VGA_HS, VGA_VS  out  1 each  syncs, active-low
- VGA_BLANK_N  out  1  low outside the visible region
- VGA_SYNC_N  out  1  tied 0 (sync-on-green unused)
- frame_start  out  1  one-Clk pulse at start of each frame

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Phase register toggles every Clk; pixel_ce = phase. Reset sets phase 0, so first pixel_ce is the second cycle after Reset deasserts.
- On a pixel_ce cycle: hc increments; at hc = H_TOTAL-1, hc wraps to 0 and vc increments; at vc = V_TOTAL-1 with the line wrap, vc wraps to 0. Counters hold on non-pixel_ce cycles.
- DrawX = hc, DrawY = vc, direct from registers, stable for both Clk cycles of a pixel.
- active = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- hs_n = 0 when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
- vs_n = 0 when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
- Colour out = active ? {Red,Green,Blue} : 0. Mapper output is never passed through during blanking.
- frame_start: registered, high for exactly one Clk, in the cycle after counters wrap from (799,524) to (0,0).
- Reset mid-frame: next cycle hc=0, vc=0, phase 0, all outputs at reset values; no partial sync pulse retained.
- Reset values: pixel_ce 0, DrawX 0, DrawY 0, VGA_R/G/B 0, VGA_HS 1, VGA_VS 1, VGA_BLANK_N 0, VGA_SYNC_N 0, frame_start 0.

## Timing
- Pixel period 2 Clk; line 1600 Clk; frame 840 000 Clk.
- With output registers (see Configuration): VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N captured on the pixel_ce edge from the pre-increment hc/vc and the current Red/Green/Blue; pins lag DrawX/DrawY by exactly one pixel (2 Clk); colour, sync and blank share that same latency.
- Red/Green/Blue must be valid by the pixel_ce edge; the mapper has a full 2-Clk window.

## Configuration
- VGA_OUT_REG_EN defined: pin outputs registered as above, one-pixel latency, glitch-free pins.
- VGA_OUT_REG_EN undefined: pin outputs are combinational from current hc/vc and Red/Green/Blue, zero latency; reset values still hold because counters are 0 during reset (VGA_BLANK_N then follows active at (0,0) after reset; colour forced to 0 while Reset is high).

## Test plan
- Assert Reset 3 cycles, release -> all outputs at reset values during Reset; pixel_ce pattern 0,1,0,1 after release; DrawX reaches 1 on the third Clk after release.
- Run one line -> hc wraps 799->0 every 1600 Clk; VGA_HS low for exactly 192 Clk, starting one pixel after DrawX=656 (VGA_OUT_REG_EN defined).
- Run one full frame -> VGA_VS low for 2 lines (3200 Clk) starting one pixel after DrawY=490, DrawX=0; frame_start pulses once, 840 000 Clk apart, width 1 Clk.
- Hold Red=FF, Green=80, Blue=7F -> pins show FF/80/7F with VGA_BLANK_N=1 for DrawX 0..639, DrawY 0..479; pins 0 and VGA_BLANK_N=0 for DrawX=640 and DrawY=480.
- Drive Red = DrawX[7:0] -> VGA_R at pixel n equals n-1 (registered build) or n (combinational build).
- Assert Reset at DrawX=300, DrawY=200 -> next cycle DrawX=0, DrawY=0, VGA_HS=VGA_VS=1, colour 0; timing after release identical to power-on.

Source files
------------

// File: rtl/vga_scan_driver.sv
`timescale 1ns/1ps
// VGA raster timing generator and pin driver: 25 MHz pixel tick from 50 MHz Clk, DrawX/DrawY, syncs, blanking.
// Define VGA_OUT_REG_EN for registered pins (one-pixel latency); otherwise the pins are combinational.
module vga_scan_driver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        r_phase;
    logic        r_frameStart;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;

    logic        w_lineEnd;
    logic        w_frameEnd;
    logic        w_active;
    logic        w_hsN;
    logic        w_vsN;
    logic [23:0] w_colour;

    always_comb begin
        w_lineEnd  = (r_hc == H_LAST);
        w_frameEnd = w_lineEnd && (r_vc == V_LAST);
        w_active   = (r_hc < H_ACT_END) && (r_vc < V_ACT_END);
        w_hsN      = !((r_hc >= HS_START) && (r_hc < HS_END));
        w_vsN      = !((r_vc >= VS_START) && (r_vc < VS_END));
        w_colour   = w_active ? {Red, Green, Blue} : 24'd0;
    end

    // Counters advance only on the pixel tick; frame_start is raised by the same edge that wraps them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase      <= 1'b0;
            r_hc         <= 10'd0;
            r_vc         <= 10'd0;
            r_frameStart <= 1'b0;
        end else begin
            r_phase      <= ~r_phase;
            r_frameStart <= r_phase && w_frameEnd;
            if (r_phase) begin
                if (w_lineEnd) begin
                    r_hc <= 10'd0;
                    r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
                end else begin
                    r_hc <= r_hc + 10'd1;
                end
            end
        end
    end

    assign pixel_ce    = r_phase;
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign frame_start = r_frameStart;
    assign VGA_SYNC_N  = 1'b0;

`ifdef VGA_OUT_REG_EN
    logic [23:0] r_colour;
    logic        r_hsN;
    logic        r_vsN;
    logic        r_blankN;

    // Pins sample the pre-increment position so colour, sync and blank all lag DrawX by one pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_colour <= 24'd0;
            r_hsN    <= 1'b1;
            r_vsN    <= 1'b1;
            r_blankN <= 1'b0;
        end else if (r_phase) begin
            r_colour <= w_colour;
            r_hsN    <= w_hsN;
            r_vsN    <= w_vsN;
            r_blankN <= w_active;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = r_colour;
    assign VGA_HS                = r_hsN;
    assign VGA_VS                = r_vsN;
    assign VGA_BLANK_N           = r_blankN;
`else
    // Reset gating keeps the pins at their idle values even in the cycle Reset is first seen.
    assign {VGA_R, VGA_G, VGA_B} = Reset ? 24'd0 : w_colour;
    assign VGA_HS                = Reset | w_hsN;
    assign VGA_VS                = Reset | w_vsN;
    assign VGA_BLANK_N           = ~Reset & w_active;
`endif

endmodule

// File: tb/tb_vga_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_scan_driver; vertical timing shrunk to 10 lines so whole frames fit the run.
// Expected pin latency follows VGA_OUT_REG_EN.
module tb_vga_scan_driver;
    localparam int VV = 4;
    localparam int VF = 2;
    localparam int VSW = 2;
    localparam int VB = 2;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FRAME_CLK = 1600 * VT;
`ifdef VGA_OUT_REG_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    typedef struct packed {
        logic        pce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync;
    } exp_t;

    logic       Clk;
    logic       Reset;
    logic       pixel_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       frame_start;

    exp_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;
    int    k = 0;

    vga_scan_driver #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pixel_ce(pixel_ce), .DrawX(DrawX), .DrawY(DrawY),
        .Red(Red), .Green(Green), .Blue(Blue), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .frame_start(frame_start)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // The mapper colour depends only on the pixel index: constant in the first frame, coordinates afterwards.
    function automatic logic [23:0] colourFor(input int n);
        int x;
        int y;
        x = n % 800;
        y = (n / 800) % VT;
        if (n / (800 * VT) == 0) return 24'hFF807F;
        return {x[7:0], y[7:0], 8'h5A};
    endfunction

    function automatic exp_t pinsFor(input int n, input bit idle);
        exp_t e;
        int   x;
        int   y;
        bit   act;
        e = '0;
        x = n % 800;
        y = (n / 800) % VT;
        act = (x < 640) && (y < VV);
        e.rgb   = (act && !idle) ? colourFor(n) : 24'd0;
        e.hs    = idle || !(x >= 656 && x < 752);
        e.vs    = idle || !(y >= VV + VF && y < VV + VF + VSW);
        e.blank = act && !idle;
        return e;
    endfunction

    function automatic exp_t expectFor(input int kk, input bit rstNow);
        exp_t e;
        int   n;
        n = kk / 2;
        if (REG_OUT) e = pinsFor((kk < 2) ? 0 : n - 1, kk < 2);
        else         e = pinsFor(n, rstNow);
        e.pce  = 1'(kk % 2);
        e.x    = 10'(n % 800);
        e.y    = 10'((n / 800) % VT);
        e.fs   = (kk > 0) && (kk % FRAME_CLK == 0);
        e.sync = 1'b0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // One entry per Clk: k counts edges since Reset was last sampled high.
    task automatic applyStimulus(input string tag, input int cycles, input bit rst);
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk);
            #1;
            if (Reset) k = 0;
            else       k = k + 1;
            Reset = rst;
            {Red, Green, Blue} = colourFor(k / 2);
            expQ.push_back(expectFor(k, rst));
            tagQ.push_back(tag);
        end
    endtask

    int  cycle = 0;
    int  hsLow = 0;
    int  vsLow = 0;
    int  hsPulses = 0;
    int  vsPulses = 0;
    int  fsPulses = 0;
    int  fsWidth = 0;
    int  lastFs = 0;
    bit  fsSeen = 1'b0;
    bit  prevHs = 1'b1;
    bit  prevVs = 1'b1;
    bit  prevFs = 1'b0;

    always @(negedge Clk) begin
        exp_t  e;
        exp_t  a;
        string t;
        cycle++;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            a = {pixel_ce, DrawX, DrawY, frame_start, VGA_R, VGA_G, VGA_B,
                 VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N};
            checkOutput(t, 64'(a), 64'(e));

            if (prevHs && VGA_HS == 1'b0) begin
                hsLow = 0;
                checkOutput("hs fall DrawX", 64'(DrawX), 64'(656 + int'(REG_OUT)));
            end
            if (VGA_HS == 1'b0) hsLow++;
            if (!prevHs && VGA_HS == 1'b1) begin
                hsPulses++;
                checkOutput("hs low width", 64'(hsLow), 64'(192));
            end
            prevHs = (VGA_HS == 1'b1);

            if (prevVs && VGA_VS == 1'b0) begin
                vsLow = 0;
                checkOutput("vs fall DrawY/DrawX", 64'({DrawY, DrawX}), 64'({10'(VV + VF), 10'(REG_OUT)}));
            end
            if (VGA_VS == 1'b0) vsLow++;
            if (!prevVs && VGA_VS == 1'b1) begin
                vsPulses++;
                checkOutput("vs low width", 64'(vsLow), 64'(1600 * VSW));
            end
            prevVs = (VGA_VS == 1'b1);

            if (frame_start == 1'b1) begin
                if (!prevFs) begin
                    fsWidth = 0;
                    fsPulses++;
                    if (fsSeen) checkOutput("frame_start period", 64'(cycle - lastFs), 64'(FRAME_CLK));
                    lastFs = cycle;
                    fsSeen = 1'b1;
                end
                fsWidth++;
            end
            if (prevFs && frame_start == 1'b0) checkOutput("frame_start width", 64'(fsWidth), 64'(1));
            prevFs = (frame_start == 1'b1);
            if (Reset) fsSeen = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Power-on reset, two frames plus two lines, reset at (300, 2), then restart from the origin.
    initial begin
        Reset = 1'b1;
        {Red, Green, Blue} = 24'hFF807F;
        $display("[TB] start, registered pins = %0d", REG_OUT);
        applyStimulus("power-on reset", 3, 1'b1);
        applyStimulus("free run", 35801, 1'b0);
        applyStimulus("mid-frame reset", 2, 1'b1);
        applyStimulus("restart", 4000, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        checkOutput("queue drained", 64'(expQ.size()), 64'(0));
        checkOutput("hs pulse count", 64'(hsPulses), 64'(24));
        checkOutput("vs pulse count", 64'(vsPulses), 64'(2));
        checkOutput("frame_start count", 64'(fsPulses), 64'(2));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
